fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_pkg.sv | 12 +
 rtl/if_id_reg.sv | 32 +++
 rtl/fetch_stage.sv | 100 ++++++++++
 tb/tb_fetch_stage.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and defaults for the instruction fetch stage
package fetch_pkg;

    localparam int          FETCH_WIDTH    = 32;
    localparam logic [31:0] FETCH_RESET_PC = 32'h0000_0000;

    typedef enum logic {
        S_BOOT = 1'b0,
        S_RUN  = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/if_id_reg.sv
// rtl/if_id_reg.sv - IF/ID pipeline register bank with hold and valid squash
module if_id_reg #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hold,
    input  logic             valid_in,
    input  logic [WIDTH-1:0] instr_in,
    input  logic [WIDTH-1:0] pc_in,
    input  logic [WIDTH-1:0] pcplus4_in,
    output logic [WIDTH-1:0] instr_D,
    output logic [WIDTH-1:0] PC_D,
    output logic [WIDTH-1:0] PCPlus4_D,
    output logic             valid_D
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            instr_D   <= '0;
            PC_D      <= '0;
            PCPlus4_D <= '0;
            valid_D   <= 1'b0;
        end else if (!hold) begin
            instr_D   <= instr_in;
            PC_D      <= pc_in;
            PCPlus4_D <= pcplus4_in;
            valid_D   <= valid_in;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - PC sequencing and synchronous-ROM fetch feeding the IF/ID register
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int               WIDTH    = FETCH_WIDTH,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(FETCH_RESET_PC)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             Stall,
    input  logic             PCsrc,
    input  logic [WIDTH-1:0] ImmOp,
    output logic [WIDTH-1:0] imem_addr,
    input  logic [WIDTH-1:0] imem_data,
    output logic [WIDTH-1:0] instr_D,
    output logic [WIDTH-1:0] PC_D,
    output logic [WIDTH-1:0] PCPlus4_D,
    output logic             valid_D
);

    localparam logic [WIDTH-1:0] FOUR       = WIDTH'(4);
    localparam logic [WIDTH-1:0] ALIGN_MASK = ~WIDTH'(3);

    fetch_state_t     state, state_next;
    logic [WIDTH-1:0] pcf, pcf_next;
    logic [WIDTH-1:0] pc_q, pc_q_next;
    logic             inflight_valid, inflight_next;
    logic             ifid_hold, ifid_valid_in;
    logic             redirect;
    logic [WIDTH-1:0] target;

    // Branches only resolve against a real instruction and never while decode is busy
    assign redirect = (state == S_RUN) && PCsrc && valid_D && !Stall;
    assign target   = (PC_D + ImmOp) & ALIGN_MASK;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= S_BOOT;
            pcf            <= RESET_PC;
            pc_q           <= RESET_PC;
            inflight_valid <= 1'b0;
        end else begin
            state          <= state_next;
            pcf            <= pcf_next;
            pc_q           <= pc_q_next;
            inflight_valid <= inflight_next;
        end
    end

    always_comb begin
        state_next    = state;
        imem_addr     = pcf;
        pcf_next      = pcf;
        pc_q_next     = pc_q;
        inflight_next = inflight_valid;
        ifid_hold     = 1'b0;
        ifid_valid_in = inflight_valid;
        case (state)
            S_BOOT: begin
                state_next    = S_RUN;
                pc_q_next     = RESET_PC;
                pcf_next      = RESET_PC + FOUR;
                inflight_next = 1'b1;
                ifid_valid_in = 1'b0;
            end
            S_RUN: begin
                if (Stall) begin
                    // Re-read pc_q so the ROM output is still the right word on release
                    imem_addr = pc_q;
                    ifid_hold = 1'b1;
                end else if (redirect) begin
                    imem_addr     = target;
                    pc_q_next     = target;
                    pcf_next      = target + FOUR;
                    inflight_next = 1'b1;
                    ifid_valid_in = 1'b0;
                end else begin
                    pc_q_next     = pcf;
                    pcf_next      = pcf + FOUR;
                    inflight_next = 1'b1;
                end
            end
        endcase
    end

    if_id_reg #(.WIDTH(WIDTH)) u_if_id (
        .clk        (clk),
        .rst        (rst),
        .hold       (ifid_hold),
        .valid_in   (ifid_valid_in),
        .instr_in   (imem_data),
        .pc_in      (pc_q),
        .pcplus4_in (pc_q + FOUR),
        .instr_D    (instr_D),
        .PC_D       (PC_D),
        .PCPlus4_D  (PCPlus4_D),
        .valid_D    (valid_D)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed self-checking bench for fetch_stage
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        Stall = 1'b0;
    logic        PCsrc = 1'b0;
    logic [31:0] ImmOp = '0;
    logic [31:0] imem_addr;
    logic [31:0] imem_data = '0;
    logic [31:0] instr_D, PC_D, PCPlus4_D;
    logic        valid_D;

    logic        stall2 = 1'b0;
    logic        pcsrc2 = 1'b0;
    logic [31:0] imm2 = '0;
    logic [31:0] imem_addr2;
    logic [31:0] imem_data2 = '0;
    logic [31:0] instr2, pc2, pc42;
    logic        valid2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // Synchronous ROM models with ROM[a] = a
    always @(posedge clk) begin
        imem_data  <= imem_addr;
        imem_data2 <= imem_addr2;
    end

    fetch_stage #(.WIDTH(32), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst), .Stall(Stall), .PCsrc(PCsrc), .ImmOp(ImmOp),
        .imem_addr(imem_addr), .imem_data(imem_data), .instr_D(instr_D),
        .PC_D(PC_D), .PCPlus4_D(PCPlus4_D), .valid_D(valid_D)
    );

    fetch_stage #(.WIDTH(32), .RESET_PC(32'hFFFF_FFF8)) dut_wrap (
        .clk(clk), .rst(rst), .Stall(stall2), .PCsrc(pcsrc2), .ImmOp(imm2),
        .imem_addr(imem_addr2), .imem_data(imem_data2), .instr_D(instr2),
        .PC_D(pc2), .PCPlus4_D(pc42), .valid_D(valid2)
    );

    task automatic test_reset();
        rst = 1'b0; Stall = 1'b0; PCsrc = 1'b0; ImmOp = '0;
        repeat (2) @(negedge clk);
        n_checks++; if (valid_D !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b exp 0", valid_D); end
        n_checks++; if (PC_D !== 32'h0) begin n_fail++; $display("FAIL rst_pc: got %h exp 0", PC_D); end
        n_checks++; if (instr_D !== 32'h0) begin n_fail++; $display("FAIL rst_instr: got %h exp 0", instr_D); end
        n_checks++; if (PCPlus4_D !== 32'h0) begin n_fail++; $display("FAIL rst_pc4: got %h exp 0", PCPlus4_D); end
        n_checks++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL rst_addr: got %h exp 0", imem_addr); end
        n_checks++; if (imem_addr2 !== 32'hFFFF_FFF8) begin n_fail++; $display("FAIL rst_addr2: got %h exp fffffff8", imem_addr2); end
        rst = 1'b1;
    endtask

    task automatic test_free_run();
        @(negedge clk);
        n_checks++; if (valid_D !== 1'b0) begin n_fail++; $display("FAIL boot_valid: got %b exp 0", valid_D); end
        n_checks++; if (imem_addr !== 32'h4) begin n_fail++; $display("FAIL boot_addr: got %h exp 4", imem_addr); end
        @(negedge clk);
        n_checks++; if (valid_D !== 1'b1 || PC_D !== 32'h0 || instr_D !== 32'h0 || PCPlus4_D !== 32'h4) begin n_fail++; $display("FAIL first_fetch: got v=%b pc=%h i=%h p4=%h exp v=1 pc=0 i=0 p4=4", valid_D, PC_D, instr_D, PCPlus4_D); end
        n_checks++; if (valid2 !== 1'b1 || pc2 !== 32'hFFFF_FFF8) begin n_fail++; $display("FAIL wrap0: got v=%b pc=%h exp v=1 pc=fffffff8", valid2, pc2); end
        @(negedge clk);
        n_checks++; if (PC_D !== 32'h4 || instr_D !== 32'h4) begin n_fail++; $display("FAIL run_pc4: got pc=%h i=%h exp 4", PC_D, instr_D); end
        n_checks++; if (pc2 !== 32'hFFFF_FFFC || pc42 !== 32'h0) begin n_fail++; $display("FAIL wrap1: got pc=%h p4=%h exp fffffffc 0", pc2, pc42); end
        @(negedge clk);
        n_checks++; if (PC_D !== 32'h8 || PCPlus4_D !== 32'hC || valid_D !== 1'b1) begin n_fail++; $display("FAIL run_pc8: got pc=%h p4=%h v=%b exp 8 c 1", PC_D, PCPlus4_D, valid_D); end
        n_checks++; if (pc2 !== 32'h0 || instr2 !== 32'h0 || valid2 !== 1'b1) begin n_fail++; $display("FAIL wrap2: got pc=%h i=%h v=%b exp 0 0 1", pc2, instr2, valid2); end
    endtask

    task automatic test_branch();
        PCsrc = 1'b1; ImmOp = 32'h10;
        #1;
        n_checks++; if (imem_addr !== 32'h18) begin n_fail++; $display("FAIL br_addr: got %h exp 18", imem_addr); end
        @(negedge clk);
        n_checks++; if (valid_D !== 1'b0 || PC_D !== 32'hC) begin n_fail++; $display("FAIL br_bubble: got v=%b pc=%h exp 0 c", valid_D, PC_D); end
        PCsrc = 1'b0; ImmOp = '0;
        @(negedge clk);
        n_checks++; if (valid_D !== 1'b1 || PC_D !== 32'h18 || PCPlus4_D !== 32'h1C || instr_D !== 32'h18) begin n_fail++; $display("FAIL br_target: got v=%b pc=%h p4=%h i=%h exp 1 18 1c 18", valid_D, PC_D, PCPlus4_D, instr_D); end
    endtask

    task automatic test_stall();
        Stall = 1'b1;
        #1;
        n_checks++; if (imem_addr !== 32'h1C) begin n_fail++; $display("FAIL st_addr: got %h exp 1c", imem_addr); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++; if (PC_D !== 32'h18 || valid_D !== 1'b1 || instr_D !== 32'h18 || imem_addr !== 32'h1C) begin n_fail++; $display("FAIL st_hold%0d: got pc=%h v=%b i=%h a=%h exp 18 1 18 1c", i, PC_D, valid_D, instr_D, imem_addr); end
        end
        Stall = 1'b0;
        @(negedge clk);
        n_checks++; if (PC_D !== 32'h1C || instr_D !== 32'h1C || valid_D !== 1'b1) begin n_fail++; $display("FAIL st_release: got pc=%h i=%h v=%b exp 1c 1c 1", PC_D, instr_D, valid_D); end
        @(negedge clk);
        n_checks++; if (PC_D !== 32'h20 || instr_D !== 32'h20) begin n_fail++; $display("FAIL st_next: got pc=%h i=%h exp 20", PC_D, instr_D); end
    endtask

    task automatic test_stall_branch();
        Stall = 1'b1; PCsrc = 1'b1; ImmOp = 32'h42;
        #1;
        n_checks++; if (imem_addr !== 32'h24) begin n_fail++; $display("FAIL sb_addr: got %h exp 24", imem_addr); end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_checks++; if (PC_D !== 32'h20 || valid_D !== 1'b1) begin n_fail++; $display("FAIL sb_hold%0d: got pc=%h v=%b exp 20 1", i, PC_D, valid_D); end
        end
        Stall = 1'b0;
        #1;
        n_checks++; if (imem_addr !== 32'h60) begin n_fail++; $display("FAIL sb_target: got %h exp 60", imem_addr); end
        @(negedge clk);
        n_checks++; if (valid_D !== 1'b0 || PC_D !== 32'h24) begin n_fail++; $display("FAIL sb_bubble: got v=%b pc=%h exp 0 24", valid_D, PC_D); end
        ImmOp = 32'h100;
        #1;
        n_checks++; if (imem_addr !== 32'h64) begin n_fail++; $display("FAIL sb_invalid_ignored: got %h exp 64", imem_addr); end
        @(negedge clk);
        n_checks++; if (valid_D !== 1'b1 || PC_D !== 32'h60 || instr_D !== 32'h60) begin n_fail++; $display("FAIL sb_landed: got v=%b pc=%h i=%h exp 1 60 60", valid_D, PC_D, instr_D); end
        PCsrc = 1'b0; ImmOp = '0;
    endtask

    task automatic test_back_to_back();
        PCsrc = 1'b1; ImmOp = 32'hFFFF_FFE0;
        #1;
        n_checks++; if (imem_addr !== 32'h40) begin n_fail++; $display("FAIL bk_addr: got %h exp 40", imem_addr); end
        @(negedge clk);
        n_checks++; if (valid_D !== 1'b0 || PC_D !== 32'h64) begin n_fail++; $display("FAIL bk_bubble: got v=%b pc=%h exp 0 64", valid_D, PC_D); end
        PCsrc = 1'b0; ImmOp = '0;
        @(negedge clk);
        n_checks++; if (valid_D !== 1'b1 || PC_D !== 32'h40) begin n_fail++; $display("FAIL bk_target: got v=%b pc=%h exp 1 40", valid_D, PC_D); end
        @(negedge clk);
        n_checks++; if (PC_D !== 32'h44 || instr_D !== 32'h44) begin n_fail++; $display("FAIL bk_next: got pc=%h i=%h exp 44", PC_D, instr_D); end
    endtask

    task automatic test_reset_mid_redirect();
        PCsrc = 1'b1; ImmOp = 32'h100;
        #2 rst = 1'b0;
        #1;
        n_checks++; if (valid_D !== 1'b0 || PC_D !== 32'h0 || imem_addr !== 32'h0) begin n_fail++; $display("FAIL mr_async: got v=%b pc=%h a=%h exp 0 0 0", valid_D, PC_D, imem_addr); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_checks++; if (valid_D !== 1'b0 || imem_addr !== 32'h4) begin n_fail++; $display("FAIL mr_boot: got v=%b a=%h exp 0 4", valid_D, imem_addr); end
        PCsrc = 1'b0; ImmOp = '0;
        @(negedge clk);
        n_checks++; if (valid_D !== 1'b1 || PC_D !== 32'h0) begin n_fail++; $display("FAIL mr_first: got v=%b pc=%h exp 1 0", valid_D, PC_D); end
        @(negedge clk);
        n_checks++; if (PC_D !== 32'h4 || valid_D !== 1'b1) begin n_fail++; $display("FAIL mr_second: got pc=%h v=%b exp 4 1", PC_D, valid_D); end
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_branch();
        test_stall();
        test_stall_branch();
        test_back_to_back();
        test_reset_mid_redirect();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
